// File: rtl/mmio_console_tx.sv
// mmio_console_tx
// Memory-mapped console transmitter. Answers the CPU data-memory read/write
// channels for a 64-byte register window at BASE. Bytes written to TXDATA are
// queued in a small FIFO and sent out as 8N1 UART frames on txd. Writes to
// EXIT latch a 32-bit exit code and pulse exit_valid for one cycle.
//
// Register window (byte offsets, only addr[31:6] is compared against BASE):
//   0x1c TXDATA  write-only, wstrb[0] pushes wdata[7:0]; reads 0
//   0x20 STATUS  read: [0] tx_busy, [1] fifo_full, [2] fifo_empty,
//                      [15:8] FIFO count (saturated at 255)
//   0x2c EXIT    read/write full word, strobes ignored
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   dmem_wready       CPU write request strobe
//   dmem_wvalid       write can be accepted (low only for TXDATA while full)
//   dmem_waddr/wdata/wstrb  write address, data, byte strobes
//   dmem_rready       CPU read request strobe
//   dmem_rvalid       read can be accepted (always 1)
//   dmem_raddr        read address
//   dmem_rresp        read data valid, one cycle after the accepted read
//   dmem_rdata        read data, holds its value between responses
//   txd               UART serial output, idles high
//   exit_valid        one-cycle pulse after an EXIT write
//   exit_code         last word written to EXIT
//
// TX FSM states:
//   state   | meaning
//   S_IDLE  | line high; pops the FIFO head when the FIFO is non-empty
//   S_START | start bit (low) for DIVISOR clocks
//   S_DATA  | 8 data bits, LSB first, DIVISOR clocks each
//   S_STOP  | stop bit (high) for DIVISOR clocks

module mmio_console_tx #(
    parameter logic [31:0] BASE    = 32'h9000_0000,
    parameter int unsigned DIVISOR = 16,
    parameter int unsigned DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_wready,
    output logic        dmem_wvalid,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    input  logic        dmem_rready,
    output logic        dmem_rvalid,
    input  logic [31:0] dmem_raddr,
    output logic        dmem_rresp,
    output logic [31:0] dmem_rdata,
    output logic        txd,
    output logic        exit_valid,
    output logic [31:0] exit_code
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BAUD_W = $clog2(DIVISOR);

    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DEPTH);

    localparam logic [5:0] OFF_TXDATA = 6'h1c;
    localparam logic [5:0] OFF_STATUS = 6'h20;
    localparam logic [5:0] OFF_EXIT   = 6'h2c;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              fifo_full, fifo_empty;

    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              baud_tc;
    logic              txd_q, txd_d;

    logic              w_hit, w_txdata, w_exit, r_hit;
    logic              wr_acc, push, pop;

    logic [31:0]       exit_code_q;
    logic              exit_valid_q;
    logic              rresp_q;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       status_word;
    logic [8:0]        count_ext;
    logic [7:0]        count_sat;

    logic              unused_ok;
    assign unused_ok = ^dmem_wstrb[3:1];

    // ---------------- address decode / handshake ----------------
    assign w_hit    = dmem_waddr[31:6] == BASE[31:6];
    assign w_txdata = w_hit && (dmem_waddr[5:0] == OFF_TXDATA);
    assign w_exit   = w_hit && (dmem_waddr[5:0] == OFF_EXIT);
    assign r_hit    = dmem_raddr[31:6] == BASE[31:6];

    assign fifo_full  = count_q == CNT_FULL;
    assign fifo_empty = count_q == '0;

    // Only a TXDATA write into a full FIFO is back-pressured; this also
    // guarantees push never happens while full, so push+pop stays in range.
    assign dmem_wvalid = !(w_txdata && fifo_full);
    assign dmem_rvalid = 1'b1;

    assign wr_acc = dmem_wready && dmem_wvalid;
    assign push   = wr_acc && w_txdata && dmem_wstrb[0];
    assign pop    = (state_q == S_IDLE) && !fifo_empty;

    // ---------------- TX FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= dmem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- TX FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            txd_q     <= txd_d;
        end
    end

    // ---------------- TX FSM: next state ----------------
    // Baud timer is a down-counter reloaded on entry to each bit; reaching
    // zero marks the last clock of the current bit.
    assign baud_tc = baud_q == '0;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        case (state_q)
            S_IDLE: begin
                baud_d = BAUD_RELOAD;
                if (!fifo_empty) begin
                    state_d   = S_START;
                    shift_d   = fifo_mem[rd_ptr_q];
                    bit_idx_d = '0;
                end
            end
            S_START: begin
                baud_d = baud_tc ? BAUD_RELOAD : baud_q - BAUD_W'(1);
                if (baud_tc) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_tc ? BAUD_RELOAD : baud_q - BAUD_W'(1);
                if (baud_tc) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                baud_d = baud_tc ? BAUD_RELOAD : baud_q - BAUD_W'(1);
                if (baud_tc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- TX FSM: output ----------------
    // Decoded from the next state so the registered txd lines up with the
    // state register (start bit appears the clock after the pop).
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    assign txd = txd_q;

    // ---------------- EXIT register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            exit_code_q  <= '0;
            exit_valid_q <= 1'b0;
        end else begin
            exit_valid_q <= wr_acc && w_exit;
            if (wr_acc && w_exit) begin
                exit_code_q <= dmem_wdata;
            end
        end
    end

    assign exit_code  = exit_code_q;
    assign exit_valid = exit_valid_q;

    // ---------------- read path ----------------
    // STATUS reflects registered state, so a read in the same cycle as a
    // push reports the pre-push count.
    assign count_ext = 9'(count_q);
    assign count_sat = count_ext[8] ? 8'hff : count_ext[7:0];

    assign status_word = {16'h0000, count_sat, 5'b00000,
                          fifo_empty, fifo_full, (state_q != S_IDLE)};

    always_comb begin
        rdata_d = '0;
        if (r_hit) begin
            case (dmem_raddr[5:0])
                OFF_STATUS: rdata_d = status_word;
                OFF_EXIT:   rdata_d = exit_code_q;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rresp_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            rresp_q <= dmem_rready;
            if (dmem_rready) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign dmem_rresp = rresp_q;
    assign dmem_rdata = rdata_q;

endmodule
